// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive front end: synchronizes D+/D-, recovers bit timing,
// NRZI-decodes and unstuffs the stream, and reports bytes, end-of-packet and errors.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic [1:0] err_code
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_CNT   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] SAMPLE_CNT = TW'(SAMPLE_PT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SYNC     = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_EOP_WAIT = 3'd3;
    localparam logic [2:0] S_ERROR    = 3'd4;

    localparam logic [1:0] ERR_SYNC    = 2'b01;
    localparam logic [1:0] ERR_STUFF   = 2'b10;
    localparam logic [1:0] ERR_PARTIAL = 2'b11;

    logic          dpMeta_q, dpSync_q, dpPrev_q;
    logic          dmMeta_q, dmSync_q, dmPrev_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          prevLevel_q, prevLevel_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [2:0]    ones_q, ones_d;
    logic          seenSe0_q, seenSe0_d;
    logic [7:0]    rxData_q, rxData_d;
    logic          rxValid_q, rxValid_d;
    logic          rxActive_q, rxActive_d;
    logic          rxEop_q, rxEop_d;
    logic          rxError_q, rxError_d;
    logic [1:0]    errCode_q, errCode_d;

    logic          lineSe0, lineJ, lineK, prevJ, dpEdge, sampleNow, bitVal;
    logic [7:0]    shiftIn;
    logic          errSet;
    logic [1:0]    errVal;

    // Synchronizers reset to the idle J pattern so an idle bus shows no edge at reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpMeta_q <= 1'b1;
            dpSync_q <= 1'b1;
            dpPrev_q <= 1'b1;
            dmMeta_q <= 1'b0;
            dmSync_q <= 1'b0;
            dmPrev_q <= 1'b0;
        end else begin
            dpMeta_q <= d_plus;
            dpSync_q <= dpMeta_q;
            dpPrev_q <= dpSync_q;
            dmMeta_q <= d_minus;
            dmSync_q <= dmMeta_q;
            dmPrev_q <= dmSync_q;
        end
    end

    assign lineSe0   = !dpSync_q && !dmSync_q;
    assign lineJ     = dpSync_q && !dmSync_q;
    assign lineK     = !dpSync_q && dmSync_q;
    assign prevJ     = dpPrev_q && !dmPrev_q;
    assign dpEdge    = (dpSync_q != dpPrev_q) && !lineSe0;
    assign sampleNow = (timer_q == SAMPLE_CNT);
    assign bitVal    = (dpSync_q == prevLevel_q);
    assign shiftIn   = {bitVal, shift_q[7:1]};

    always_comb begin
        state_d     = state_q;
        prevLevel_d = prevLevel_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        ones_d      = ones_q;
        seenSe0_d   = seenSe0_q;
        rxData_d    = rxData_q;
        rxValid_d   = 1'b0;
        rxActive_d  = rxActive_q;
        rxEop_d     = 1'b0;
        rxError_d   = rxError_q;
        errCode_d   = errCode_q;
        errSet      = 1'b0;
        errVal      = 2'b00;
        timer_d     = (dpEdge || timer_q == LAST_CNT) ? '0 : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                prevLevel_d = 1'b1;
                if (prevJ && lineK) begin
                    state_d   = S_SYNC;
                    timer_d   = '0;
                    bitCnt_d  = 3'd0;
                    seenSe0_d = 1'b0;
                    rxError_d = 1'b0;
                    errCode_d = 2'b00;
                end
            end
            S_SYNC: if (sampleNow) begin
                if (lineSe0) begin
                    state_d   = S_ERROR;
                    seenSe0_d = 1'b1;
                    errSet    = 1'b1;
                    errVal    = ERR_SYNC;
                end else begin
                    prevLevel_d = dpSync_q;
                    shift_d     = shiftIn;
                    bitCnt_d    = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        bitCnt_d = 3'd0;
                        ones_d   = 3'd0;
                        if (shiftIn == 8'h80) begin
                            state_d    = S_DATA;
                            rxActive_d = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                            errSet  = 1'b1;
                            errVal  = ERR_SYNC;
                        end
                    end
                end
            end
            // After six consecutive ones the next bit is a stuff bit and never reaches the byte.
            S_DATA: if (sampleNow) begin
                if (lineSe0) begin
                    state_d = S_EOP_WAIT;
                    if (bitCnt_q != 3'd0) begin
                        errSet = 1'b1;
                        errVal = ERR_PARTIAL;
                    end
                end else begin
                    prevLevel_d = dpSync_q;
                    if (ones_q == 3'd6) begin
                        ones_d = 3'd0;
                        if (bitVal) begin
                            state_d   = S_ERROR;
                            seenSe0_d = 1'b0;
                            errSet    = 1'b1;
                            errVal    = ERR_STUFF;
                        end
                    end else begin
                        ones_d   = bitVal ? ones_q + 3'd1 : 3'd0;
                        shift_d  = shiftIn;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            rxData_d  = shiftIn;
                            rxValid_d = 1'b1;
                        end
                    end
                end
            end
            S_EOP_WAIT: if (sampleNow) begin
                if (lineJ) begin
                    state_d    = S_IDLE;
                    rxEop_d    = 1'b1;
                    rxActive_d = 1'b0;
                end else if (lineK) begin
                    state_d   = S_ERROR;
                    seenSe0_d = 1'b0;
                    errSet    = 1'b1;
                    errVal    = ERR_SYNC;
                end
            end
            S_ERROR: if (sampleNow) begin
                if (lineSe0) begin
                    seenSe0_d = 1'b1;
                end else if (seenSe0_q && lineJ) begin
                    state_d    = S_IDLE;
                    rxActive_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only the first error of a packet is recorded.
        if (errSet) begin
            rxError_d = 1'b1;
            if (!rxError_q) errCode_d = errVal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            prevLevel_q <= 1'b1;
            shift_q     <= 8'h00;
            bitCnt_q    <= 3'd0;
            ones_q      <= 3'd0;
            seenSe0_q   <= 1'b0;
            rxData_q    <= 8'h00;
            rxValid_q   <= 1'b0;
            rxActive_q  <= 1'b0;
            rxEop_q     <= 1'b0;
            rxError_q   <= 1'b0;
            errCode_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            prevLevel_q <= prevLevel_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            ones_q      <= ones_d;
            seenSe0_q   <= seenSe0_d;
            rxData_q    <= rxData_d;
            rxValid_q   <= rxValid_d;
            rxActive_q  <= rxActive_d;
            rxEop_q     <= rxEop_d;
            rxError_q   <= rxError_d;
            errCode_q   <= errCode_d;
        end
    end

    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign rx_active = rxActive_q;
    assign rx_eop    = rxEop_q;
    assign rx_error  = rxError_q;
    assign err_code  = errCode_q;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: drives NRZI bus symbols (optionally edge-jittered)
// while a monitor matches every rx_valid/rx_eop pulse against queued expectations.
module tb_usb_rx_decoder;
    localparam int BIT = 8;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    typedef struct {
        bit         isEop;
        logic [7:0] data;
    } event_t;

    logic       clk;
    logic       rst;
    logic       d_plus;
    logic       d_minus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;
    logic [1:0] err_code;

    event_t     expQ[$];
    int         checks;
    int         failures;
    logic [1:0] curSym;
    int         curShift;
    bit         jitLate;

    usb_rx_decoder #(.CLKS_PER_BIT(8), .SAMPLE_PT(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_active(rx_active),
        .rx_eop   (rx_eop),
        .rx_error (rx_error),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushEvent(input bit isEop, input logic [7:0] data);
        event_t e;
        e.isEop = isEop;
        e.data  = data;
        expQ.push_back(e);
    endtask

    task automatic matchEvent(input bit isEop, input logic [7:0] data);
        event_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected %s: got 1 expected 0", isEop ? "rx_eop" : "rx_valid");
        end else begin
            e = expQ.pop_front();
            checkOutput(isEop ? "eop order" : "valid order", int'(isEop), int'(e.isEop));
            if (!isEop) checkOutput("rx_data at rx_valid", data, e.data);
        end
    endtask

    // Every reported byte or end-of-packet must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rx_valid) matchEvent(1'b0, rx_data);
        if (rx_eop)   matchEvent(1'b1, 8'h00);
    end

    // Finishes the current symbol, then starts a new one; a level change moves the edge by +/-1 clk when jit is set.
    task automatic applyStimulus(input logic [1:0] sym, input bit jit);
        int sNew;
        sNew = 0;
        if (jit && sym != curSym) begin
            sNew    = jitLate ? 1 : -1;
            jitLate = !jitLate;
        end
        repeat (BIT + sNew - curShift) @(negedge clk);
        {d_plus, d_minus} = sym;
        curSym   = sym;
        curShift = sNew;
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n, input bit jit);
        for (int i = 0; i < n; i++) begin
            if (bits[i]) applyStimulus(curSym, jit);
            else         applyStimulus((curSym == SYM_J) ? SYM_K : SYM_J, jit);
        end
    endtask

    task automatic idleBits(input int n);
        for (int i = 0; i < n; i++) applyStimulus(SYM_J, 1'b0);
    endtask

    task automatic sendEop(input bit jit);
        applyStimulus(SYM_SE0, jit);
        applyStimulus(SYM_SE0, jit);
        applyStimulus(SYM_J, jit);
    endtask

    task automatic sendPacket(input logic [15:0] bits, input int n, input bit jit);
        sendBits(16'h0080, 8, jit);
        sendBits(bits, n, jit);
        sendEop(jit);
        idleBits(2);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        d_plus   = 1'b1;
        d_minus  = 1'b0;
        curSym   = SYM_J;
        curShift = 0;
        jitLate  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset rx_data", rx_data, 8'h00);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset rx_active", rx_active, 0);
        checkOutput("reset rx_eop", rx_eop, 0);
        checkOutput("reset rx_error", rx_error, 0);
        checkOutput("reset err_code", err_code, 0);
        rst = 1'b0;
        idleBits(3);

        $display("[TB] packet 8'hA5");
        pushEvent(1'b0, 8'hA5);
        pushEvent(1'b1, 8'h00);
        sendPacket(16'h00A5, 8, 1'b0);
        checkOutput("A5 pending events", expQ.size(), 0);
        checkOutput("A5 rx_error", rx_error, 0);
        checkOutput("A5 err_code", err_code, 0);
        checkOutput("A5 rx_active", rx_active, 0);

        // 8'hFF on the wire: six ones, a stuffed zero, then the last two ones.
        $display("[TB] packet 8'hFF with stuff bit");
        pushEvent(1'b0, 8'hFF);
        pushEvent(1'b1, 8'h00);
        sendPacket(16'h01BF, 9, 1'b0);
        checkOutput("FF pending events", expQ.size(), 0);
        checkOutput("FF rx_error", rx_error, 0);
        checkOutput("FF rx_data", rx_data, 8'hFF);

        $display("[TB] seven ones without stuff bit");
        sendBits(16'h0080, 8, 1'b0);
        sendBits(16'h007F, 7, 1'b0);
        applyStimulus(SYM_SE0, 1'b0);
        checkOutput("stuff rx_error", rx_error, 1);
        checkOutput("stuff err_code", err_code, 2'b10);
        checkOutput("stuff rx_active", rx_active, 1);
        sendEop(1'b0);
        idleBits(2);
        checkOutput("stuff recovered rx_active", rx_active, 0);
        checkOutput("stuff sticky err_code", err_code, 2'b10);
        checkOutput("stuff pending events", expQ.size(), 0);

        // A short K glitch makes the first decoded bit a one, giving SYNC 8'h81.
        $display("[TB] corrupted SYNC 8'h81");
        applyStimulus(SYM_K, 1'b0);
        repeat (2) @(negedge clk);
        {d_plus, d_minus} = SYM_J;
        curSym = SYM_J;
        sendBits(16'h0040, 7, 1'b0);
        applyStimulus(SYM_SE0, 1'b0);
        checkOutput("sync rx_error", rx_error, 1);
        checkOutput("sync err_code", err_code, 2'b01);
        checkOutput("sync rx_active", rx_active, 0);
        applyStimulus(SYM_SE0, 1'b0);
        applyStimulus(SYM_J, 1'b0);
        idleBits(2);
        checkOutput("sync recovered rx_active", rx_active, 0);
        checkOutput("sync sticky err_code", err_code, 2'b01);

        $display("[TB] packet 8'h96 after recovery");
        pushEvent(1'b0, 8'h96);
        pushEvent(1'b1, 8'h00);
        sendPacket(16'h0096, 8, 1'b0);
        checkOutput("96 pending events", expQ.size(), 0);
        checkOutput("96 rx_error cleared", rx_error, 0);
        checkOutput("96 err_code cleared", err_code, 0);

        $display("[TB] 12 data bits");
        pushEvent(1'b0, 8'hC3);
        pushEvent(1'b1, 8'h00);
        sendPacket(16'h05C3, 12, 1'b0);
        checkOutput("partial pending events", expQ.size(), 0);
        checkOutput("partial rx_error", rx_error, 1);
        checkOutput("partial err_code", err_code, 2'b11);
        checkOutput("partial rx_data", rx_data, 8'hC3);
        checkOutput("partial rx_active", rx_active, 0);

        $display("[TB] jittered packet 8'h3C");
        pushEvent(1'b0, 8'h3C);
        pushEvent(1'b1, 8'h00);
        sendPacket(16'h003C, 8, 1'b1);
        checkOutput("jitter pending events", expQ.size(), 0);
        checkOutput("jitter rx_error", rx_error, 0);
        checkOutput("jitter rx_data", rx_data, 8'h3C);

        $display("[TB] reset mid-byte");
        sendBits(16'h0080, 8, 1'b0);
        sendBits(16'h000A, 4, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre-reset rx_active", rx_active, 1);
        rst = 1'b1;
        {d_plus, d_minus} = SYM_J;
        curSym   = SYM_J;
        curShift = 0;
        @(negedge clk);
        checkOutput("mid reset rx_active", rx_active, 0);
        checkOutput("mid reset rx_data", rx_data, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idleBits(3);
        checkOutput("post reset rx_active", rx_active, 0);
        checkOutput("post reset rx_error", rx_error, 0);
        pushEvent(1'b0, 8'h5A);
        pushEvent(1'b1, 8'h00);
        sendPacket(16'h005A, 8, 1'b0);
        checkOutput("5A pending events", expQ.size(), 0);
        checkOutput("5A rx_data", rx_data, 8'h5A);
        checkOutput("5A rx_error", rx_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
